// File: rtl/regfile_2w2r_sb_if.sv
// Port bundle for the dual-write / dual-read register file with busy scoreboard.
// The master side drives writes, reads and issue; the slave side is the register file.
interface regfile_2w2r_sb_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          we0;
  logic [AW-1:0] wa0;
  logic [DW-1:0] wd0;
  logic          we1;
  logic [AW-1:0] wa1;
  logic [DW-1:0] wd1;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic          hz1;
  logic          hz2;
  logic [AW:0]   busy_cnt;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
    input  rd1, rd2, hz1, hz2, busy_cnt
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
    output rd1, rd2, hz1, hz2, busy_cnt
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with optional write-to-read bypass, optional
// hardwired zero register and a per-register busy scoreboard for RAW hazard detection.
module regfile_2w2r_sb #(
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  regfile_2w2r_sb_if.slave  bus
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0]   rf [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     cnt_q;
  logic            we0_eff;
  logic            we1_eff;
  logic            iss_eff;
  logic [DW-1:0]   rd1_c;
  logic [DW-1:0]   rd2_c;
  logic            hz1_c;
  logic            hz2_c;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic fwd_hit(input logic en, input logic [AW-1:0] wa,
                                   input logic [AW-1:0] ra);
    return (BYPASS != 0) && en && (wa == ra);
  endfunction

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + {{AW{1'b0}}, v[i]};
    return n;
  endfunction

  // Writes and issues aimed at a hardwired zero register are dropped here, so
  // neither the store nor the scoreboard ever sees them.
  assign we0_eff = bus.we0    && !is_zero(bus.wa0);
  assign we1_eff = bus.we1    && !is_zero(bus.wa1);
  assign iss_eff = bus.iss_en && !is_zero(bus.iss_addr);

  // Port 1 is written last so it takes priority on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (we0_eff) rf[bus.wa0] <= bus.wd0;
      if (we1_eff) rf[bus.wa1] <= bus.wd1;
    end
  end

  // Retiring writes clear busy; a same-cycle issue to the same register re-sets it.
  always_comb begin
    busy_nxt = busy;
    if (we0_eff) busy_nxt[bus.wa0] = 1'b0;
    if (we1_eff) busy_nxt[bus.wa1] = 1'b0;
    if (iss_eff) busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_q <= popcount(busy_nxt);
    end
  end

  always_comb begin
    rd1_c = rf[bus.ra1];
    if (fwd_hit(we1_eff, bus.wa1, bus.ra1))      rd1_c = bus.wd1;
    else if (fwd_hit(we0_eff, bus.wa0, bus.ra1)) rd1_c = bus.wd0;
    if (is_zero(bus.ra1)) rd1_c = '0;

    rd2_c = rf[bus.ra2];
    if (fwd_hit(we1_eff, bus.wa1, bus.ra2))      rd2_c = bus.wd1;
    else if (fwd_hit(we0_eff, bus.wa0, bus.ra2)) rd2_c = bus.wd0;
    if (is_zero(bus.ra2)) rd2_c = '0;
  end

  // A pending result being forwarded this cycle resolves the hazard.
  always_comb begin
    hz1_c = busy[bus.ra1] && !is_zero(bus.ra1)
         && !(fwd_hit(we0_eff, bus.wa0, bus.ra1) || fwd_hit(we1_eff, bus.wa1, bus.ra1));
    hz2_c = busy[bus.ra2] && !is_zero(bus.ra2)
         && !(fwd_hit(we0_eff, bus.wa0, bus.ra2) || fwd_hit(we1_eff, bus.wa1, bus.ra2));
  end

  assign bus.rd1      = rd1_c;
  assign bus.rd2      = rd2_c;
  assign bus.hz1      = hz1_c;
  assign bus.hz2      = hz2_c;
  assign bus.busy_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Bench for regfile_2w2r_sb: two instances (zero-reg+bypass, plain) share one stimulus
// stream; a behavioural model is checked every cycle alongside hand-computed literals.
module tb_regfile_2w2r_sb;
  logic        clk;
  logic        rst;
  logic        we0, we1, iss_en;
  logic [2:0]  wa0, wa1, ra1, ra2, iss_addr;
  logic [15:0] wd0, wd1;
  logic        check_en;
  int          nvec;
  int          nmis;

  // Behavioural model state: index 0 = ZERO_REG=1/BYPASS=1, index 1 = ZERO_REG=0/BYPASS=0.
  logic [15:0] mrf   [2][8];
  logic        mbusy [2][8];

  regfile_2w2r_sb_if #(.DW(16), .AW(3)) ifa ();
  regfile_2w2r_sb_if #(.DW(16), .AW(3)) ifb ();

  assign ifa.we0 = we0;  assign ifa.wa0 = wa0;  assign ifa.wd0 = wd0;
  assign ifa.we1 = we1;  assign ifa.wa1 = wa1;  assign ifa.wd1 = wd1;
  assign ifa.ra1 = ra1;  assign ifa.ra2 = ra2;
  assign ifa.iss_en = iss_en;  assign ifa.iss_addr = iss_addr;
  assign ifb.we0 = we0;  assign ifb.wa0 = wa0;  assign ifb.wd0 = wd0;
  assign ifb.we1 = we1;  assign ifb.wa1 = wa1;  assign ifb.wd1 = wd1;
  assign ifb.ra1 = ra1;  assign ifb.ra2 = ra2;
  assign ifb.iss_en = iss_en;  assign ifb.iss_addr = iss_addr;

  regfile_2w2r_sb #(.DW(16), .AW(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  regfile_2w2r_sb #(.DW(16), .AW(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit zr(int c);  return c == 0; endfunction
  function automatic bit byp(int c); return c == 0; endfunction

  function automatic logic [15:0] exp_rd(int c, logic [2:0] ra);
    if (zr(c) && ra == 3'd0) return 16'h0000;
    if (byp(c) && we1 && wa1 == ra) return wd1;
    if (byp(c) && we0 && wa0 == ra) return wd0;
    return mrf[c][ra];
  endfunction

  function automatic logic exp_hz(int c, logic [2:0] ra);
    if (zr(c) && ra == 3'd0) return 1'b0;
    if (byp(c) && ((we0 && wa0 == ra) || (we1 && wa1 == ra))) return 1'b0;
    return mbusy[c][ra];
  endfunction

  function automatic int exp_cnt(int c);
    int n = 0;
    for (int k = 0; k < 8; k++) if (mbusy[c][k]) n++;
    return n;
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        for (int k = 0; k < 8; k++) begin
          mrf[c][k]   = 16'h0000;
          mbusy[c][k] = 1'b0;
        end
      end else begin
        if (we0 && !(zr(c) && wa0 == 3'd0)) begin mrf[c][wa0] = wd0; mbusy[c][wa0] = 1'b0; end
        if (we1 && !(zr(c) && wa1 == 3'd0)) begin mrf[c][wa1] = wd1; mbusy[c][wa1] = 1'b0; end
        if (iss_en && !(zr(c) && iss_addr == 3'd0)) mbusy[c][iss_addr] = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("a_rd1", 32'(ifa.rd1), 32'(exp_rd(0, ra1)));
      chk("a_rd2", 32'(ifa.rd2), 32'(exp_rd(0, ra2)));
      chk("a_hz1", 32'(ifa.hz1), 32'(exp_hz(0, ra1)));
      chk("a_hz2", 32'(ifa.hz2), 32'(exp_hz(0, ra2)));
      chk("a_cnt", 32'(ifa.busy_cnt), 32'(exp_cnt(0)));
      chk("b_rd1", 32'(ifb.rd1), 32'(exp_rd(1, ra1)));
      chk("b_rd2", 32'(ifb.rd2), 32'(exp_rd(1, ra2)));
      chk("b_hz1", 32'(ifb.hz1), 32'(exp_hz(1, ra1)));
      chk("b_hz2", 32'(ifb.hz2), 32'(exp_hz(1, ra2)));
      chk("b_cnt", 32'(ifb.busy_cnt), 32'(exp_cnt(1)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #5;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = 3'd0; wd0 = 16'h0000;
    we1 = 1'b0; wa1 = 3'd0; wd1 = 16'h0000;
    iss_en = 1'b0; iss_addr = 3'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nvec = 0; nmis = 0; check_en = 1'b0;
    rst = 1'b1; ra1 = 3'd0; ra2 = 3'd0;
    idle();
    cyc(); cyc();
    rst = 1'b0; check_en = 1'b1;

    // Reset state across all addresses
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); ra2 = 3'(7 - i);
      peek();
      chk("rst_rd1", 32'(ifa.rd1), 32'h0);
      chk("rst_rd2", 32'(ifa.rd2), 32'h0);
      chk("rst_hz1", 32'(ifa.hz1), 32'h0);
      chk("rst_hz2", 32'(ifa.hz2), 32'h0);
      chk("rst_cnt", 32'(ifa.busy_cnt), 32'h0);
      cyc();
    end

    // Same-address dual write: port 1 wins
    we0 = 1'b1; wa0 = 3'd3; wd0 = 16'hAAAA;
    we1 = 1'b1; wa1 = 3'd3; wd1 = 16'h5555;
    cyc(); idle(); ra1 = 3'd3;
    peek();
    chk("prio_a", 32'(ifa.rd1), 32'h5555);
    chk("prio_b", 32'(ifb.rd1), 32'h5555);
    cyc();

    // Bypass versus stored path
    we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h1234; ra2 = 3'd5;
    peek();
    chk("byp_a", 32'(ifa.rd2), 32'h1234);
    chk("nobyp_b", 32'(ifb.rd2), 32'h0);
    cyc(); idle();
    peek();
    chk("stored_b", 32'(ifb.rd2), 32'h1234);
    cyc();

    // Zero register
    we1 = 1'b1; wa1 = 3'd0; wd1 = 16'hFFFF; ra1 = 3'd0;
    peek();
    chk("zr_byp_a", 32'(ifa.rd1), 32'h0);
    chk("zr_byp_b", 32'(ifb.rd1), 32'h0);
    cyc(); idle(); ra1 = 3'd0; iss_en = 1'b1; iss_addr = 3'd0;
    peek();
    chk("zr_rd_a", 32'(ifa.rd1), 32'h0);
    chk("zr_rd_b", 32'(ifb.rd1), 32'hFFFF);
    cyc(); idle();
    peek();
    chk("zr_iss_a", 32'(ifa.busy_cnt), 32'd0);
    chk("zr_iss_b", 32'(ifb.busy_cnt), 32'd1);
    cyc();

    // Issue 2,4,6 then retire 4
    iss_en = 1'b1; iss_addr = 3'd2; cyc();
    iss_addr = 3'd4; cyc();
    iss_addr = 3'd6; cyc();
    idle(); ra1 = 3'd4;
    peek();
    chk("iss3_cnt_a", 32'(ifa.busy_cnt), 32'd3);
    chk("iss3_hz_a", 32'(ifa.hz1), 32'd1);
    chk("iss3_hz_b", 32'(ifb.hz1), 32'd1);
    cyc();
    we0 = 1'b1; wa0 = 3'd4; wd0 = 16'h0444;
    peek();
    chk("ret_hz_a", 32'(ifa.hz1), 32'd0);
    chk("ret_hz_b", 32'(ifb.hz1), 32'd1);
    chk("ret_rd_a", 32'(ifa.rd1), 32'h0444);
    cyc(); idle();
    peek();
    chk("ret_cnt_a", 32'(ifa.busy_cnt), 32'd2);
    chk("ret_cnt_b", 32'(ifb.busy_cnt), 32'd3);
    cyc();

    // Issue and write same register: stays busy
    iss_en = 1'b1; iss_addr = 3'd6; we1 = 1'b1; wa1 = 3'd6; wd1 = 16'h0666;
    cyc(); idle(); ra1 = 3'd6;
    peek();
    chk("setwin_cnt", 32'(ifa.busy_cnt), 32'd2);
    chk("setwin_hz", 32'(ifa.hz1), 32'd1);
    chk("setwin_rd", 32'(ifa.rd1), 32'h0666);
    cyc();

    // Reset overrides a same-cycle write and issue
    rst = 1'b1; we0 = 1'b1; wa0 = 3'd2; wd0 = 16'hBEEF; iss_en = 1'b1; iss_addr = 3'd3;
    cyc(); rst = 1'b0; idle(); ra1 = 3'd2; ra2 = 3'd3;
    peek();
    chk("mrst_rd_a", 32'(ifa.rd1), 32'h0);
    chk("mrst_rd_b", 32'(ifb.rd1), 32'h0);
    chk("mrst_cnt_a", 32'(ifa.busy_cnt), 32'd0);
    chk("mrst_cnt_b", 32'(ifb.busy_cnt), 32'd0);
    chk("mrst_hz_a", 32'(ifa.hz2), 32'd0);
    cyc();

    // Fill the scoreboard: NREG reachable only without a zero register
    for (int i = 0; i < 8; i++) begin
      iss_en = 1'b1; iss_addr = 3'(i); cyc();
    end
    idle();
    peek();
    chk("full_cnt_a", 32'(ifa.busy_cnt), 32'd7);
    chk("full_cnt_b", 32'(ifb.busy_cnt), 32'd8);
    cyc();
    iss_en = 1'b1; iss_addr = 3'd3;
    cyc(); idle();
    peek();
    chk("reiss_cnt_b", 32'(ifb.busy_cnt), 32'd8);
    cyc();
    we0 = 1'b1; wa0 = 3'd1; wd0 = 16'h0101;
    we1 = 1'b1; wa1 = 3'd2; wd1 = 16'h0202;
    cyc(); idle(); ra1 = 3'd1; ra2 = 3'd2;
    peek();
    chk("dual_cnt_a", 32'(ifa.busy_cnt), 32'd5);
    chk("dual_cnt_b", 32'(ifb.busy_cnt), 32'd6);
    chk("dual_rd1", 32'(ifa.rd1), 32'h0101);
    chk("dual_rd2", 32'(ifa.rd2), 32'h0202);
    cyc();
    we0 = 1'b1; wa0 = 3'd1; wd0 = 16'h1111;
    cyc(); idle();
    peek();
    chk("nbusy_cnt_a", 32'(ifa.busy_cnt), 32'd5);
    cyc();

    // Deterministic mixed traffic, checked by the model every cycle
    for (int i = 0; i < 48; i++) begin
      we0 = 1'(i % 3 != 0);  wa0 = 3'(i * 3);      wd0 = 16'(i * 4369 + 7);
      we1 = 1'(i % 4 == 1);  wa1 = 3'(i * 5 + 1);  wd1 = 16'(i * 2731 + 3);
      iss_en = 1'(i % 2);    iss_addr = 3'(i * 7 + 2);
      ra1 = 3'(i);           ra2 = 3'(i * 3 + 1);
      cyc();
    end
    idle();
    cyc();
    peek();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
